m_store_buffer: RTL
===================

# m_store_buffer

Posted-write buffer between the M-stage pipeline register and the data memory of the pipelined MIPS core. M-stage stores are queued with their PC, word address, data and byte enables, and written to the data memory later. The block drains stores only in cycles when the DM port is not needed by a load or an incoming store. Loads see pending stores through byte-merged forwarding, so the W stage always receives up-to-date data.

## Interface
- DEPTH, 4: entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- st_valid  in  1  M-stage store this cycle
- ld_valid  in  1  M-stage load this cycle
- PC  in  32  PC of the M-stage instruction
- Addr  in  32  byte address; Addr[31:2] is the word address
- WD  in  32  store data, already lane-aligned
- BE  in  4  store byte enables; BE[i] covers WD[8i+7:8i]
- dm_rd  in  32  combinational read data from DM at dm_addr
- stall  out  1  freeze F/D/E/M this cycle
- dm_we  out  1  DM write strobe
- dm_pc  out  32  PC of the draining store, used for the DM write log
- dm_addr  out  32  DM address: {word,2'b0}
- dm_wd  out  32  DM write data
- dm_be  out  4  DM byte enables
- RD  out  32  load data to the M/W register
- empty  out  1  no pending entries

## Operation
- Circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- Entry fields: pc, word address (30 bits), data, be.
- st_valid and ld_valid asserted together is illegal. In that case the block treats the cycle as a load and drops the store.
- Drain condition: !empty && !ld_valid && (!st_valid || full). It is also true when a forwarding-disabled load hits a pending store (see Configuration).
  - On drain: dm_we=1 and dm_addr/dm_wd/dm_be/dm_pc are taken from the head entry. The head pops at the posedge.
- When not draining: dm_we=0, dm_addr={Addr[31:2],2'b0}, dm_be=0.
- Store push: happens when st_valid && !full. Tail advances at the posedge.
- Full store: when st_valid && full, stall=1, no push, and the head drains. The push happens in the next cycle.
- Load: RD is dm_rd merged with every valid entry whose word address matches Addr[31:2]. Entries are applied oldest to youngest, per byte, using that entry's be. The youngest write wins each byte.
- Push and pop never occur in the same cycle.
- A pop reduces count by 1 and a push increases it by 1; count never exceeds DEPTH.

## Timing
- Outputs are combinational from state and inputs; there is no added load latency. RD is valid in the same cycle as ld_valid.
- Store in cycle N is visible to forwarding in cycle N+1. The earliest DM write is the posedge ending cycle N+1.
- Reset (synchronous): count=0, pointers=0, all entries invalid, pending stores discarded. While reset is high: dm_we=0, stall=0, empty=1 at the next edge.
- Reset asserted mid-drain: the write in that cycle is suppressed.
- stall is combinational. The upstream stage must hold PC/Addr/WD/BE/st_valid/ld_valid stable while stall=1.

## Configuration
- STORE_FWD_EN defined: load hits are forwarded as described; loads never stall.
- STORE_FWD_EN undefined: a load whose word address matches any valid entry forces stall=1.
  - The DM port drains the head that cycle and the load is not performed.
  - The stall repeats until no match remains; RD then equals dm_rd.

## Structure
- Package m_sb_pkg holds the DEPTH default, the entry struct {pc, waddr[29:0], wd, be}, and the match/merge helper widths.
- One sub-module, m_sb_fwd: combinational per-byte match-and-merge over the entry array. Only its match vector is used when STORE_FWD_EN is undefined.

## Test plan
- Reset, then store Addr 0x10, WD 0x12345678, BE 4'hF, PC 0x3000, then idle. Required: in the next cycle dm_we=1, dm_addr=0x10, dm_pc=0x3000; empty=1 after the edge.
- Five back-to-back stores to 0x0,0x4,...,0x10 (DEPTH 4). Required: in the 5th cycle stall=1 and dm_we=1 with dm_addr=0x0; the 0x10 store pushes in the 6th cycle; idle cycles then drain 0x4,0x8,0xC,0x10 in order.
- DM[0x20]=0x11223344; store 0x20, WD 0xAABBCCDD, BE 4'b0011; then load 0x20. Required with STORE_FWD_EN: RD=0x1122CCDD, stall=0. Without STORE_FWD_EN: stall=1 for one cycle with dm_we=1, then RD=0x1122CCDD.
- Store 0x40 0xAAAAAAAA BE 4'hF, then store 0x40 0xBB000000 BE 4'b1000, then load 0x40 (STORE_FWD_EN). Required: RD=0xBBAAAAAA.
- Three entries pending, assert reset for one cycle. Required: next cycle empty=1, dm_we=0; DM contents unchanged.
- Entries pending at 0x0/0x4; load 0x80 where DM holds 0xCAFEF00D. Required: RD=0xCAFEF00D, dm_we=0 that cycle, count unchanged.

Source files
------------

// File: rtl/m_sb_pkg.sv
// Shared types for the M-stage store buffer: entry layout, field widths and the
// per-byte merge helper used by forwarding.
package m_sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_WAW   = 30;   // word address width
    localparam int SB_DW    = 32;
    localparam int SB_BEW   = SB_DW / 8;

    typedef struct packed {
        logic [31:0]        pc;
        logic [SB_WAW-1:0]  waddr;
        logic [SB_DW-1:0]   wd;
        logic [SB_BEW-1:0]  be;
    } sb_entry_t;

    // Overlay the enabled bytes of wd onto base.
    function automatic logic [SB_DW-1:0] sb_merge(input logic [SB_DW-1:0]  base,
                                                  input logic [SB_DW-1:0]  wd,
                                                  input logic [SB_BEW-1:0] be);
        logic [SB_DW-1:0] r;
        r = base;
        for (int b = 0; b < SB_BEW; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/m_sb_fwd.sv
// Combinational word-address match and oldest-to-youngest byte merge over the
// store buffer entries. With MERGE_EN=0 only the match vector is meaningful.
module m_sb_fwd
    import m_sb_pkg::*;
#(
    parameter int DEPTH    = SB_DEPTH,
    parameter bit MERGE_EN = 1'b1
) (
    input  sb_entry_t [DEPTH-1:0]       ent,
    input  logic [DEPTH-1:0]            vld,
    input  logic [$clog2(DEPTH)-1:0]    head,
    input  logic [SB_WAW-1:0]           waddr,
    input  logic [SB_DW-1:0]            base,
    output logic [DEPTH-1:0]            match,
    output logic [SB_DW-1:0]            merged
);

    localparam int PW = $clog2(DEPTH);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld[i] && (ent[i].waddr == waddr);
        end
    end

    // Walk from head so the youngest matching store lands last and wins each byte.
    always_comb begin
        logic [PW-1:0] idx;
        idx    = '0;
        merged = base;
        if (MERGE_EN) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + PW'(k);
                if (match[idx]) merged = sb_merge(merged, ent[idx].wd, ent[idx].be);
            end
        end
    end

endmodule

// File: rtl/m_store_buffer.sv
// Posted-write buffer between the M stage and data memory. Define STORE_FWD_EN to
// forward pending stores to loads; otherwise a load hitting a pending store stalls.
module m_store_buffer
    import m_sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic        ld_valid,
    input  logic [31:0] PC,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [3:0]  BE,
    input  logic [31:0] dm_rd,
    output logic        stall,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [3:0]  dm_be,
    output logic [31:0] RD,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    sb_entry_t [DEPTH-1:0] ent;
    logic [PW-1:0]         head, tail;
    logic [PW:0]           count;
    logic [DEPTH-1:0]      vld, match;
    logic [SB_DW-1:0]      fwd_rd;
    logic                  full, hit, ld_block, drain, push;
    sb_entry_t             hd;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Addr[1:0];

    assign full  = (count == CNT_DEPTH);
    assign empty = (count == '0);
    assign hd    = ent[head];

    // An entry is live if it sits within count slots of head.
    always_comb begin
        logic [PW-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = PW'(i) - head;
            vld[i] = ({1'b0, off} < count);
        end
    end

    m_sb_fwd #(
        .DEPTH    (DEPTH),
        .MERGE_EN (FWD)
    ) u_fwd (
        .ent    (ent),
        .vld    (vld),
        .head   (head),
        .waddr  (Addr[31:2]),
        .base   (dm_rd),
        .match  (match),
        .merged (fwd_rd)
    );

    assign hit      = |match;
    assign ld_block = !FWD && ld_valid && hit;

    // A simultaneous load and store is treated as a load; the store is dropped.
    assign drain = !empty && ((!ld_valid && (!st_valid || full)) || ld_block);
    assign push  = st_valid && !ld_valid && !full;

    always_comb begin
        stall   = 1'b0;
        dm_we   = 1'b0;
        dm_pc   = PC;
        dm_addr = {Addr[31:2], 2'b00};
        dm_wd   = WD;
        dm_be   = 4'h0;
        if (!reset) begin
            stall = (st_valid && !ld_valid && full) || ld_block;
            if (drain) begin
                dm_we   = 1'b1;
                dm_pc   = hd.pc;
                dm_addr = {hd.waddr, 2'b00};
                dm_wd   = hd.wd;
                dm_be   = hd.be;
            end
        end
    end

    assign RD = fwd_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail  <= tail + PTR_ONE;
                count <= count + CNT_ONE;
            end else if (drain) begin
                head  <= head + PTR_ONE;
                count <= count - CNT_ONE;
            end
        end
    end

    // Payload needs no reset; liveness comes from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent[tail] <= '{pc: PC, waddr: Addr[31:2], wd: WD, be: BE};
        end
    end

endmodule
